// File: rtl/templ_stats_scan.sv
// templ_stats_scan: template sum/sum-of-squares accumulator and search-row shift-window scanner
// Ports: start begins a frame; f_valid/f_data/f_ready carry the WIN*WIN template stream;
//   g_valid/g_data/g_ready carry the search rows; window/col_sel/x_pos/y_pos/win_valid feed the
//   correlator; fsum/f2sum/stats_valid report template stats; busy is high outside IDLE; done
//   pulses once at frame end.
module templ_stats_scan #(
  parameter int PIX_W  = 3,
  parameter int WIN    = 16,
  parameter int SEARCH = 79,
  parameter int ROWS   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            f_valid,
  input  logic [PIX_W-1:0]                f_data,
  output logic                            f_ready,
  input  logic                            g_valid,
  input  logic [PIX_W-1:0]                g_data,
  output logic                            g_ready,
  output logic [WIN*PIX_W-1:0]            window,
  output logic [WIN-1:0]                  col_sel,
  output logic [$clog2(SEARCH)-1:0]       x_pos,
  output logic [$clog2(ROWS)-1:0]         y_pos,
  output logic                            win_valid,
  output logic [PIX_W+2*$clog2(WIN)-1:0]  fsum,
  output logic [2*PIX_W+2*$clog2(WIN)-1:0] f2sum,
  output logic                            stats_valid,
  output logic                            busy,
  output logic                            done
);
  localparam int CW = $clog2(WIN);
  localparam int XW = $clog2(SEARCH);
  localparam int YW = $clog2(ROWS);
  localparam int SW = PIX_W + 2*CW;
  localparam int QW = 2*PIX_W + 2*CW;
  typedef enum logic [1:0] {IDLE, LOAD_T, SCAN, ROW_END} state_t;
  state_t r_st, w_nxt;
  logic [2*CW-1:0]      r_fcnt;
  logic [XW-1:0]        r_gcnt;
  logic [WIN*PIX_W-1:0] r_win;
  logic [WIN-1:0]       r_col;
  logic [XW-1:0]        r_x;
  logic [YW-1:0]        r_y;
  logic [SW-1:0]        r_fsum;
  logic [QW-1:0]        r_f2sum;
  logic                 r_wv, r_sv, r_done;
  logic [2*PIX_W-1:0]   w_sq;
  logic w_fx, w_gx, w_f_last, w_g_last, w_y_last;
  assign f_ready     = r_st == LOAD_T;
  assign g_ready     = r_st == SCAN;
  assign busy        = r_st != IDLE;
  assign w_fx        = f_valid && f_ready;
  assign w_gx        = g_valid && g_ready;
  assign w_f_last    = r_fcnt == (2*CW)'(WIN*WIN-1);
  assign w_g_last    = r_gcnt == XW'(SEARCH-1);
  assign w_y_last    = r_y == YW'(ROWS-1);
  assign w_sq        = {{PIX_W{1'b0}}, f_data} * {{PIX_W{1'b0}}, f_data};
  assign window      = r_win;
  assign col_sel     = r_col;
  assign x_pos       = r_x;
  assign y_pos       = r_y;
  assign win_valid   = r_wv;
  assign fsum        = r_fsum;
  assign f2sum       = r_f2sum;
  assign stats_valid = r_sv;
  assign done        = r_done;
  always_ff @(posedge clk)
    r_st <= rst ? IDLE : w_nxt;
  always_comb begin
    w_nxt = r_st;
    case (r_st)
      IDLE:    w_nxt = start ? LOAD_T : IDLE;
      LOAD_T:  w_nxt = (w_fx && w_f_last) ? SCAN : LOAD_T;
      SCAN:    w_nxt = (w_gx && w_g_last) ? ROW_END : SCAN;
      ROW_END: w_nxt = w_y_last ? IDLE : SCAN;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt  <= '0;
      r_gcnt  <= '0;
      r_win   <= '0;
      r_col   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_fsum  <= '0;
      r_f2sum <= '0;
      r_wv    <= 1'b0;
      r_sv    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wv   <= w_gx && (r_gcnt >= XW'(WIN-1));
      r_done <= (r_st == ROW_END) && w_y_last;
      if (r_st == IDLE && start) begin
        r_fcnt  <= '0;
        r_gcnt  <= '0;
        r_win   <= '0;
        r_col   <= '0;
        r_x     <= '0;
        r_y     <= '0;
        r_fsum  <= '0;
        r_f2sum <= '0;
        r_sv    <= 1'b0;
      end
      if (w_fx) begin
        r_fsum  <= r_fsum + SW'(f_data);
        r_f2sum <= r_f2sum + QW'(w_sq);
        r_fcnt  <= r_fcnt + 1'b1;
        if (w_f_last) r_sv <= 1'b1;
      end
      // newest pixel enters the top slice; x_pos/col_sel name the pixel just accepted
      if (w_gx) begin
        r_win  <= {g_data, r_win[WIN*PIX_W-1:PIX_W]};
        r_x    <= r_gcnt;
        r_col  <= WIN'(1) << r_gcnt[CW-1:0];
        r_gcnt <= r_gcnt + 1'b1;
      end
      // rows are independent: drop all window history between them
      if (r_st == ROW_END) begin
        r_win  <= '0;
        r_x    <= '0;
        r_col  <= '0;
        r_gcnt <= '0;
        if (!w_y_last) r_y <= r_y + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_templ_stats_scan.sv
// tb_templ_stats_scan: randomized self-checking bench against a row-history reference model
module tb_templ_stats_scan;
  localparam int PIX_W  = 3;
  localparam int WIN    = 16;
  localparam int SEARCH = 79;
  localparam int ROWS   = 16;
  localparam int XW = $clog2(SEARCH);
  localparam int YW = $clog2(ROWS);
  logic clk, rst, start, f_valid, f_ready, g_valid, g_ready;
  logic [PIX_W-1:0] f_data, g_data;
  logic [WIN*PIX_W-1:0] window;
  logic [WIN-1:0] col_sel;
  logic [XW-1:0] x_pos;
  logic [YW-1:0] y_pos;
  logic win_valid, stats_valid, busy, done;
  logic [PIX_W+2*$clog2(WIN)-1:0] fsum;
  logic [2*PIX_W+2*$clog2(WIN)-1:0] f2sum;
  int n_chk = 0;
  int n_pass = 0;
  logic [PIX_W-1:0] row[$];

  templ_stats_scan #(.PIX_W(PIX_W), .WIN(WIN), .SEARCH(SEARCH), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .f_valid(f_valid), .f_data(f_data), .f_ready(f_ready),
    .g_valid(g_valid), .g_data(g_data), .g_ready(g_ready),
    .window(window), .col_sel(col_sel), .x_pos(x_pos), .y_pos(y_pos),
    .win_valid(win_valid), .fsum(fsum), .f2sum(f2sum),
    .stats_valid(stats_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIN*PIX_W-1:0] exp_win();
    logic [WIN*PIX_W-1:0] w = '0;
    int n = row.size();
    for (int k = 0; k < WIN; k++)
      if (n - WIN + k >= 0) w[k*PIX_W +: PIX_W] = row[n-WIN+k];
    return w;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fready"}, f_ready, 0);
    chk({tag, "_gready"}, g_ready, 0);
    chk({tag, "_window"}, window, 0);
    chk({tag, "_col"}, col_sel, 0);
    chk({tag, "_x"}, x_pos, 0);
    chk({tag, "_y"}, y_pos, 0);
    chk({tag, "_wv"}, win_valid, 0);
    chk({tag, "_fsum"}, fsum, 0);
    chk({tag, "_f2sum"}, f2sum, 0);
    chk({tag, "_sv"}, stats_valid, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // fm: 0 = all-7 template, 1 = random; gm: 0 = g=x mod 8 at full rate, 1 = random data/valid/start
  task automatic run_frame(input int fm, input int gm, input int abort_row);
    int nf = 0, s = 0, q = 0, fd, pulses;
    logic gv;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("busy_start", busy, 1);
    chk("sv_clr", stats_valid, 0);
    chk("fsum_clr", fsum, 0);
    chk("f2sum_clr", f2sum, 0);
    chk("y_clr", y_pos, 0);
    chk("win_clr", window, 0);
    while (nf < WIN*WIN) begin
      f_valid = (fm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      f_data = (fm == 0) ? PIX_W'(7) : PIX_W'($urandom_range(0, (1 << PIX_W) - 1));
      start = (gm == 1) && ($urandom_range(0, 7) == 0);
      chk("f_ready", f_ready, 1);
      chk("g_ready_t", g_ready, 0);
      step;
      if (f_valid) begin
        fd = int'(f_data);
        nf++;
        s += fd;
        q += fd * fd;
      end
      chk("fsum", fsum, s);
      chk("f2sum", f2sum, q);
      chk("stats_valid", stats_valid, nf == WIN*WIN);
    end
    f_valid = 1'b0;
    start = 1'b0;
    chk("f_ready_drop", f_ready, 0);
    for (int r = 0; r < ROWS; r++) begin
      row.delete();
      pulses = 0;
      chk("y_row", y_pos, r);
      while (row.size() < SEARCH) begin
        gv = (gm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        g_valid = gv;
        g_data = (gm == 0) ? PIX_W'(row.size() % 8) : PIX_W'($urandom_range(0, (1 << PIX_W) - 1));
        if (r == abort_row && row.size() == 30) begin
          rst = 1'b1;
          start = 1'b1;
          step;
          rst = 1'b0;
          start = 1'b0;
          g_valid = 1'b0;
          chk_all_zero("abort");
          repeat (4) begin
            step;
            chk("abort_done", done, 0);
            chk("abort_busy", busy, 0);
          end
          return;
        end
        start = (gm == 1) && ($urandom_range(0, 7) == 0);
        chk("g_ready", g_ready, 1);
        step;
        if (gv) row.push_back(g_data);
        chk("window", window, exp_win());
        chk("x_pos", x_pos, row.size() == 0 ? 0 : row.size() - 1);
        chk("col_sel", col_sel, row.size() == 0 ? 0 : 64'(1) << ((row.size() - 1) % WIN));
        chk("win_valid", win_valid, gv && (row.size() >= WIN));
        chk("y_pos", y_pos, r);
        if (win_valid) pulses++;
      end
      g_valid = 1'b0;
      start = 1'b0;
      chk("pulses", pulses, SEARCH - WIN + 1);
      chk("rowend_gready", g_ready, 0);
      chk("rowend_busy", busy, 1);
      chk("rowend_done", done, 0);
      step;
      chk("clr_window", window, 0);
      chk("clr_x", x_pos, 0);
      chk("clr_col", col_sel, 0);
      chk("clr_wv", win_valid, 0);
      chk("done", done, r == ROWS - 1);
      chk("busy_after_row", busy, r != ROWS - 1);
      chk("y_next", y_pos, r == ROWS - 1 ? r : r + 1);
      if (r == ROWS - 1) begin
        step;
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("sv_hold", stats_valid, 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    f_valid = 1'b1;
    g_valid = 1'b1;
    f_data = '0;
    g_data = '0;
    step;
    step;
    start = 1'b0;
    f_valid = 1'b0;
    g_valid = 1'b0;
    chk_all_zero("reset");
    rst = 1'b0;
    step;
    chk("idle_busy0", busy, 0);
    run_frame(0, 0, -1);
    run_frame(1, 1, -1);
    run_frame(1, 1, 5);
    run_frame(0, 1, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
